// File: rtl/memory_unit_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared definitions for the memory_unit slice.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths (CPU bus match)
//   DEPTH                   : number of words at the default address width
//   state_e                 : load/run phase encoding used by mem_load_fsm
// -----------------------------------------------------------------------------
package memory_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/memory_unit_if.sv
// -----------------------------------------------------------------------------
// memory_unit_if
// Bundles the CPU memory port and the loader handshake of memory_unit.
//   CPU side   : read, write, address, memoryIn -> memoryOut
//   Loader     : load_valid, load_data -> load_ready
//   Status     : load_done, cpu_hold, err
// Modports:
//   slave  : the memory itself
//   master : the CPU / loader / bench driving the memory
// -----------------------------------------------------------------------------
interface memory_unit_if
    import memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] memoryIn;
    logic [DATA_W-1:0] memoryOut;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              cpu_hold;
    logic              err;

    modport slave (
        input  read, write, address, memoryIn, load_valid, load_data,
        output memoryOut, load_ready, load_done, cpu_hold, err
    );

    modport master (
        output read, write, address, memoryIn, load_valid, load_data,
        input  memoryOut, load_ready, load_done, cpu_hold, err
    );

endinterface

// File: rtl/memory_unit_mem_load_fsm.sv
// -----------------------------------------------------------------------------
// mem_load_fsm
// Phase controller of memory_unit: owns the LOAD/RUN state and the load
// pointer, decodes the phase status outputs and steers the array write port.
// Optional feature macro: MEMORY_UNIT_WRITE_PROTECT_EN (run-phase writes
// below PROT_LIMIT are suppressed and flagged through prot_hit).
// Ports:
//   clk, clr        : clock, asynchronous active-high reset
//   load_valid      : loader word present
//   write, address  : CPU write strobe and address
//   load_ready      : loader word accepted this cycle (LOAD phase)
//   cpu_hold        : keeps the CPU cleared during LOAD
//   load_done       : RUN phase active
//   arr_we          : array write enable
//   arr_addr        : array write address
//   arr_sel_load    : 1 = write data from loader, 0 = from CPU
//   prot_hit        : run-phase write hit the protected region
// -----------------------------------------------------------------------------
module mem_load_fsm
    import memory_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LOAD_WORDS = 16,
    parameter int PROT_LIMIT = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_valid,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              arr_we,
    output logic [ADDR_W-1:0] arr_addr,
    output logic              arr_sel_load,
    output logic              prot_hit
);

    localparam logic [0:0]        ST_LOAD    = LOAD;
    localparam logic [0:0]        ST_RUN     = RUN;
    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(LOAD_WORDS - 1);
    // One extra bit so a limit equal to the depth still compares correctly.
    localparam logic [ADDR_W:0]   PROT_BOUND = (ADDR_W + 1)'(PROT_LIMIT);

`ifdef MEMORY_UNIT_WRITE_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              last_word_s;
    logic              prot_zone_s;

    assign last_word_s = (ptr_r == LAST_PTR);
    assign prot_zone_s = PROT_EN & ({1'b0, address} < PROT_BOUND);

    // Phase status is a pure decode of the state register.
    assign load_ready = (state_r == ST_LOAD);
    assign cpu_hold   = (state_r == ST_LOAD);
    assign load_done  = (state_r == ST_RUN);

    // Phase register and load pointer; the pointer parks on the last word.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_LOAD;
            ptr_r   <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (load_valid) begin
                        if (last_word_s) begin
                            state_r <= ST_RUN;
                        end else begin
                            ptr_r <= ptr_r + ADDR_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_LOAD;
                    ptr_r   <= '0;
                end
            endcase
        end
    end

    // Array write steering: loader owns the port in LOAD, the CPU in RUN.
    always_comb begin
        arr_we       = 1'b0;
        arr_addr     = '0;
        arr_sel_load = 1'b0;
        prot_hit     = 1'b0;
        case (state_r)
            ST_LOAD: begin
                arr_we       = load_valid;
                arr_addr     = ptr_r;
                arr_sel_load = 1'b1;
                prot_hit     = 1'b0;
            end
            ST_RUN: begin
                arr_we       = write & ~prot_zone_s;
                arr_addr     = address;
                arr_sel_load = 1'b0;
                prot_hit     = write & prot_zone_s;
            end
            default: begin
                arr_we       = 1'b0;
                arr_addr     = '0;
                arr_sel_load = 1'b0;
                prot_hit     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/memory_unit.sv
// -----------------------------------------------------------------------------
// memory_unit
// 16x8 program/data memory beside the CPU. After reset it is filled word by
// word through the loader handshake while cpu_hold keeps the CPU cleared;
// then it serves combinational CPU reads and clocked CPU writes.
// Optional feature macro: MEMORY_UNIT_WRITE_PROTECT_EN (run-phase writes to
// addresses below PROT_LIMIT are dropped and set err).
// Ports:
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset (restarts loading at address 0)
//   bus  : memory_unit_if.slave -- CPU port, loader handshake, status/err
// -----------------------------------------------------------------------------
module memory_unit
    import memory_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LOAD_WORDS = 16,
    parameter int PROT_LIMIT = 8
) (
    input  logic                clk,
    input  logic                clr,
    memory_unit_if.slave        bus
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];
    logic              err_r;

    logic              load_done_s;
    logic              arr_we_s;
    logic [ADDR_W-1:0] arr_addr_s;
    logic              arr_sel_load_s;
    logic              prot_hit_s;
    logic [DATA_W-1:0] arr_wdata_s;
    logic              collision_s;

    mem_load_fsm #(
        .ADDR_W     (ADDR_W),
        .LOAD_WORDS (LOAD_WORDS),
        .PROT_LIMIT (PROT_LIMIT)
    ) u_fsm (
        .clk          (clk),
        .clr          (clr),
        .load_valid   (bus.load_valid),
        .write        (bus.write),
        .address      (bus.address),
        .load_ready   (bus.load_ready),
        .cpu_hold     (bus.cpu_hold),
        .load_done    (load_done_s),
        .arr_we       (arr_we_s),
        .arr_addr     (arr_addr_s),
        .arr_sel_load (arr_sel_load_s),
        .prot_hit     (prot_hit_s)
    );

    assign bus.load_done = load_done_s;
    assign bus.err       = err_r;
    assign collision_s   = bus.read & bus.write;
    assign arr_wdata_s   = arr_sel_load_s ? bus.load_data : bus.memoryIn;

    // Zero-latency read; the pre-write value is visible in a collision cycle
    // because the array only changes at the edge.
    assign bus.memoryOut = (load_done_s & bus.read) ? mem_r[bus.address] : '0;

    // Storage array, cleared by reset so unloaded words read as zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (arr_we_s) begin
            mem_r[arr_addr_s] <= arr_wdata_s;
        end
    end

    // Sticky access error: run-phase read/write collision or protected write.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err_r <= 1'b0;
        end else if (load_done_s & (collision_s | prot_hit_s)) begin
            err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_unit
// Two memories share one stimulus stream: dut_a loads 16 words, dut_b loads
// 4 words, so both the full load and the short/stalled load are covered.
// Expected outputs come from an array-based reference model and are queued;
// a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_memory_unit;
    import memory_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    memory_unit_if bus_a ();
    memory_unit_if bus_b ();

    memory_unit #(.LOAD_WORDS(16), .PROT_LIMIT(8)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (bus_a)
    );

    memory_unit #(.LOAD_WORDS(4), .PROT_LIMIT(8)) dut_b (
        .clk (clk),
        .clr (clr),
        .bus (bus_b)
    );

`ifdef MEMORY_UNIT_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0][7:0] mo;
        logic [1:0]      lr;
        logic [1:0]      ld;
        logic [1:0]      ch;
        logic [1:0]      er;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: per-memory array, phase flag, fill count, error flag.
    logic [7:0] mem_m [2][DEPTH];
    bit         run_m [2];
    int         fill_m[2];
    bit         err_m [2];
    int         lw_m  [2] = '{16, 4};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) mem_m[i][j] = 8'h00;
            run_m[i]  = 1'b0;
            fill_m[i] = 0;
            err_m[i]  = 1'b0;
        end
    endtask

    function automatic exp_t model_expect(input bit rd, input logic [3:0] a);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.mo[i] = (run_m[i] && rd) ? mem_m[i][a] : 8'h00;
            e.lr[i] = !run_m[i];
            e.ld[i] = run_m[i];
            e.ch[i] = !run_m[i];
            e.er[i] = err_m[i];
        end
        return e;
    endfunction

    task automatic model_edge(input bit rd, input bit wr, input logic [3:0] a,
                              input logic [7:0] d, input bit lv, input logic [7:0] ldat);
        for (int i = 0; i < 2; i++) begin
            if (!run_m[i]) begin
                if (lv) begin
                    mem_m[i][fill_m[i]] = ldat;
                    fill_m[i]++;
                    if (fill_m[i] == lw_m[i]) run_m[i] = 1'b1;
                end
            end else begin
                if (wr) begin
                    if (PROT_ON && a < 4'd8) err_m[i] = 1'b1;
                    else mem_m[i][a] = d;
                end
                if (rd && wr) err_m[i] = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [3:0] a,
                         input logic [7:0] d, input bit lv, input logic [7:0] ldat);
        bus_a.read = rd;  bus_a.write = wr;  bus_a.address = a;  bus_a.memoryIn = d;
        bus_a.load_valid = lv;  bus_a.load_data = ldat;
        bus_b.read = rd;  bus_b.write = wr;  bus_b.address = a;  bus_b.memoryIn = d;
        bus_b.load_valid = lv;  bus_b.load_data = ldat;
    endtask

    // One clock: apply inputs after the edge, queue expectation, advance model.
    task automatic cycle(input bit rd, input bit wr, input logic [3:0] a,
                         input logic [7:0] d, input bit lv, input logic [7:0] ldat);
        drive(rd, wr, a, d, lv, ldat);
        exp_q.push_back(model_expect(rd, a));
        @(posedge clk);
        model_edge(rd, wr, a, d, lv, ldat);
        #1;
    endtask

    // Raise clr between edges, check outputs while it is high, release it.
    task automatic pulse_reset(input logic [3:0] a);
        drive(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00);
        clr = 1'b1;
        model_reset();
        exp_q.push_back(model_expect(1'b1, a));
        @(negedge clk);
        #1 clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int dut, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, dut, cyc, act, exp);
        end
    endtask

    // Monitor: compare the outputs presented this cycle with the queued model.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("memoryOut",  0, bus_a.memoryOut,         mon_e.mo[0]);
            check("load_ready", 0, {7'd0, bus_a.load_ready}, {7'd0, mon_e.lr[0]});
            check("load_done",  0, {7'd0, bus_a.load_done},  {7'd0, mon_e.ld[0]});
            check("cpu_hold",   0, {7'd0, bus_a.cpu_hold},   {7'd0, mon_e.ch[0]});
            check("err",        0, {7'd0, bus_a.err},        {7'd0, mon_e.er[0]});
            check("memoryOut",  1, bus_b.memoryOut,         mon_e.mo[1]);
            check("load_ready", 1, {7'd0, bus_b.load_ready}, {7'd0, mon_e.lr[1]});
            check("load_done",  1, {7'd0, bus_b.load_done},  {7'd0, mon_e.ld[1]});
            check("cpu_hold",   1, {7'd0, bus_b.cpu_hold},   {7'd0, mon_e.ch[1]});
            check("err",        1, {7'd0, bus_b.err},        {7'd0, mon_e.er[1]});
        end
    end

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] raddr();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset(4'h5);

        // Load: first word, two stall cycles, then a continuous stream.
        // CPU writes are random only while both memories are still loading.
        cycle(rbit(), rbit(), raddr(), rbyte(), 1'b1, 8'h10);
        cycle(rbit(), rbit(), raddr(), rbyte(), 1'b0, rbyte());
        cycle(rbit(), rbit(), raddr(), rbyte(), 1'b0, rbyte());
        for (int k = 1; k < 16; k++) begin
            cycle(rbit(), (k <= 3) ? rbit() : 1'b0, raddr(), rbyte(), 1'b1, 8'(8'h10 + k));
        end

        // First run cycles: loaded word, unloaded word reads zero.
        cycle(1'b1, 1'b0, 4'h5, 8'h00, 1'b1, 8'hFF);
        cycle(1'b1, 1'b0, 4'h4, 8'h00, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 4'hF, 8'h00, 1'b0, 8'h00);

        // Write then read back; read strobe low gives zero.
        cycle(1'b0, 1'b1, 4'hC, 8'h5A, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 4'hC, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 4'hC, 8'h00, 1'b0, 8'h00);

        // Protected and unprotected writes (protection only with the macro).
        cycle(1'b0, 1'b1, 4'h2, 8'h77, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 4'h9, 8'h77, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 4'h9, 8'h00, 1'b0, 8'h00);

        // Collision: pre-write value visible, err sets and sticks.
        cycle(1'b1, 1'b1, 4'h3, 8'hEE, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);

        // Random run traffic with occasional collisions.
        for (int k = 0; k < 150; k++) begin
            cycle(rbit(), ($urandom_range(0, 3) == 0), raddr(), rbyte(), rbit(), rbyte());
        end

        // Reset mid-run, reload zeros, confirm the earlier write is gone.
        pulse_reset(4'hC);
        for (int k = 0; k < 16; k++) begin
            cycle(rbit(), 1'b0, raddr(), rbyte(), 1'b1, 8'h00);
        end
        cycle(1'b1, 1'b0, 4'hC, 8'h00, 1'b0, 8'h00);

        for (int k = 0; k < 60; k++) begin
            cycle(rbit(), ($urandom_range(0, 7) == 0), raddr(), rbyte(), rbit(), rbyte());
        end

        // Reset again in the middle of a load.
        pulse_reset(4'h1);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, rbit(), raddr(), rbyte(), rbit(), rbyte());
        end

        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- 16x8 program/data memory that answers the CPU's memory port: address, read, write, write data in, read data out.
- After reset it runs a load phase. A word-per-handshake loader port fills the array and holds the CPU in clear.
- It then enters run phase and serves CPU reads combinationally and CPU writes on the clock edge.
- Sits beside the CPU at top level; its hold output is ORed into the CPU's clear.

Parameters:
- DATA_W, 8, memory word width (matches CPU bus).
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16.
- LOAD_WORDS, 16, number of words accepted in load phase (1..16). Words at and above LOAD_WORDS stay 0.
- PROT_LIMIT, 8, used only with the optional feature: addresses below this value are write-protected.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- read  input  1  CPU read strobe.
- write  input  1  CPU write strobe.
- address  input  ADDR_W  CPU address.
- memoryIn  input  DATA_W  CPU write data (CPU bus).
- memoryOut  output  DATA_W  read data to CPU.
- load_valid  input  1  loader word present.
- load_data  input  DATA_W  loader word.
- load_ready  output  1  memory accepts loader word this cycle.
- load_done  output  1  run phase active.
- cpu_hold  output  1  high during load phase; keeps CPU cleared.
- err  output  1  sticky access-error flag.

Behaviour:
- Interface is fixed: one clock (clk); reset clr is asynchronous and active-high.
- Reset (clr high, asynchronous):
  - all 16 words = 0; state = LOAD; load pointer = 0; err = 0.
  - Outputs while clr is high: memoryOut = 0, load_ready = 1, load_done = 0, cpu_hold = 1.
  - Asserting clr mid-load or mid-run aborts immediately and restarts loading from address 0.
- States: LOAD, RUN. There are no other states.
- LOAD:
  - load_ready = 1 and cpu_hold = 1, both decoded from state.
  - On a posedge with load_valid = 1: mem[ptr] <= load_data, ptr <= ptr+1.
  - When a word is accepted with ptr == LOAD_WORDS-1, next state is RUN and ptr stays at LOAD_WORDS-1 (no wrap).
  - load_valid = 0 means a wait cycle with no change.
  - CPU read/write are ignored: memoryOut = 0, no array write, err unchanged.
- RUN:
  - load_ready = 0, cpu_hold = 0, load_done = 1.
  - load_valid is ignored.
- Reads: memoryOut = mem[address] combinationally while read = 1, zero latency. This matches the CPU, which captures memory data at the end of the same cycle. memoryOut = 0 when read = 0.
- Writes: mem[address] <= memoryIn on the posedge where write = 1. A read of the same address in the following cycle returns the new value.
- read and write high in the same cycle:
  - the write is performed;
  - memoryOut shows the pre-write value during that cycle;
  - err is set at that edge.
- err stays set until clr.
- Phase transition timing:
  - the first cycle of RUN is the cycle after the final load handshake edge;
  - cpu_hold falls at that same edge, so the CPU's first fetch (T0) happens in the first RUN cycle.
- Address arithmetic is ADDR_W-bit; no out-of-range address exists.

Optional Feature:
- Macro: MEMORY_UNIT_WRITE_PROTECT_EN.
- Defined: in RUN, a write to an address < PROT_LIMIT is suppressed (array unchanged) and sets err at that edge. Load-phase writes are never protected.
- Not defined: every RUN write is performed; PROT_LIMIT is unused; err is set only by read+write collision.

Decomposition:
- Package memory_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the state enum {LOAD, RUN};
  - the DEPTH constant.
- One sub-module, mem_load_fsm, is natural. It owns:
  - the state register and load pointer;
  - the load_ready, cpu_hold and load_done decode;
  - it drives the array write enable/address/data mux select.
- The array, read mux and err logic stay in memory_unit.

Test Plan:
1. Load all 16 words:
   - Stimulus: release clr, present 0x10..0x1F on consecutive cycles with load_valid = 1.
   - Response: load_ready high for 16 cycles; load_done = 1 and cpu_hold = 0 the cycle after the 16th edge.
   - Check: address 5 with read = 1 gives memoryOut = 0x15.
2. Loader stalls:
   - Stimulus: LOAD_WORDS = 4; stream 0xA1, idle, idle, 0xA2, 0xA3, 0xA4.
   - Response: RUN entered only after 0xA4 is accepted; mem[0..3] = A1..A4; mem[4] reads 0x00.
3. Run write then read:
   - Stimulus: write = 1, address = 0xC, memoryIn = 0x5A for one edge, then read address 0xC.
   - Response: memoryOut = 0x5A in the next cycle; memoryOut = 0 when read = 0.
4. Collision:
   - Stimulus: read = write = 1, address 3 (holding 0x13), memoryIn = 0xEE.
   - Response: memoryOut = 0x13 that cycle; err = 1 after the edge; mem[3] = 0xEE; err stays 1 afterward.
5. Reset mid-run:
   - Stimulus: after scenario 3, pulse clr between clock edges.
   - Response: immediately memoryOut = 0, cpu_hold = 1, load_ready = 1, err = 0; read of 0xC after reloading zeros returns 0x00.
6. Write protect (macro defined, PROT_LIMIT = 8):
   - Stimulus: RUN write 0x77 to address 2, then 0x77 to address 9.
   - Response: mem[2] unchanged and err = 1; mem[9] = 0x77.
   - Without the macro, both writes land and err = 0.
